// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB configuration: ROB tag width, data width, FIFO depth default,
// and the source encoding used by the round-robin arbiter.
package cdb_arbiter_pkg;

    localparam int CDB_ROB_ID_W   = 5;
    localparam int CDB_XLEN       = 32;
    localparam int CDB_FIFO_DEPTH = 4;

    // Tag 0 is reserved to mean "no result" on every producer and on the bus.
    localparam logic [CDB_ROB_ID_W-1:0] ROB_TAG_NONE = '0;

    typedef enum logic {
        SRC_RS  = 1'b0,
        SRC_LSB = 1'b1
    } cdb_src_e;

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-source result queue feeding the CDB arbiter.
// Pushes into a full queue are dropped. Simultaneous push and pop are allowed.
module cdb_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        push_ok = push && (count != FULL_CNT);
        pop_ok  = pop && (count != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Storage needs no reset: entries are only read once count says they are valid.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_data;
    end

    assign head        = mem[rd_ptr];
    assign almost_full = (count >= AF_CNT);

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: queues RS and LSB results, drains them round-robin
// and broadcasts one registered result per cycle. Flushed on misprediction.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_ID_W   = CDB_ROB_ID_W,
    parameter int XLEN       = CDB_XLEN,
    parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                flush,
    input  logic [ROB_ID_W-1:0] rs_dest,
    input  logic [XLEN-1:0]     rs_value,
    input  logic [XLEN-1:0]     rs_next_pc,
    input  logic [ROB_ID_W-1:0] lsb_dest,
    input  logic [XLEN-1:0]     lsb_value,
    output logic                rs_almost_full,
    output logic                lsb_almost_full,
    output logic [ROB_ID_W-1:0] cdb_dest,
    output logic [XLEN-1:0]     cdb_value,
    output logic [XLEN-1:0]     cdb_next_pc,
    output logic                cdb_from_lsb
);

    localparam int RS_W  = ROB_ID_W + 2 * XLEN;
    localparam int LSB_W = ROB_ID_W + XLEN;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [RS_W-1:0]  rs_head;
    logic [LSB_W-1:0] lsb_head;
    logic [CNT_W-1:0] rs_count;
    logic [CNT_W-1:0] lsb_count;
    logic             rs_push;
    logic             lsb_push;
    logic             rs_pop;
    logic             lsb_pop;
    logic             fifo_flush;
    logic             grant_valid;
    cdb_src_e         grant_src;
    cdb_src_e         last_grant;

    assign fifo_flush = rdy && flush;
    assign rs_push    = rdy && !flush && (rs_dest != '0);
    assign lsb_push   = rdy && !flush && (lsb_dest != '0);

    cdb_result_fifo #(.WIDTH(RS_W), .DEPTH(FIFO_DEPTH)) u_rs_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (rs_push),
        .push_data   ({rs_dest, rs_value, rs_next_pc}),
        .pop         (rs_pop),
        .flush       (fifo_flush),
        .head        (rs_head),
        .count       (rs_count),
        .almost_full (rs_almost_full)
    );

    cdb_result_fifo #(.WIDTH(LSB_W), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (lsb_push),
        .push_data   ({lsb_dest, lsb_value}),
        .pop         (lsb_pop),
        .flush       (fifo_flush),
        .head        (lsb_head),
        .count       (lsb_count),
        .almost_full (lsb_almost_full)
    );

    // On a tie the source that did not win last time gets the bus.
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = SRC_RS;
        if ((rs_count != '0) && (lsb_count != '0)) begin
            grant_valid = 1'b1;
            grant_src   = (last_grant == SRC_LSB) ? SRC_RS : SRC_LSB;
        end else if (rs_count != '0) begin
            grant_valid = 1'b1;
            grant_src   = SRC_RS;
        end else if (lsb_count != '0) begin
            grant_valid = 1'b1;
            grant_src   = SRC_LSB;
        end
    end

    assign rs_pop  = rdy && !flush && grant_valid && (grant_src == SRC_RS);
    assign lsb_pop = rdy && !flush && grant_valid && (grant_src == SRC_LSB);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_dest     <= '0;
            cdb_value    <= '0;
            cdb_next_pc  <= '0;
            cdb_from_lsb <= 1'b0;
            last_grant   <= SRC_LSB;
        end else if (rdy) begin
            if (flush || !grant_valid) begin
                cdb_dest     <= '0;
                cdb_value    <= '0;
                cdb_next_pc  <= '0;
                cdb_from_lsb <= 1'b0;
                if (flush) last_grant <= SRC_LSB;
            end else if (grant_src == SRC_RS) begin
                {cdb_dest, cdb_value, cdb_next_pc} <= rs_head;
                cdb_from_lsb <= 1'b0;
                last_grant   <= SRC_RS;
            end else begin
                {cdb_dest, cdb_value} <= lsb_head;
                cdb_next_pc  <= '0;
                cdb_from_lsb <= 1'b1;
                last_grant   <= SRC_LSB;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected broadcasts are queued as stimulus is
// driven and compared in order whenever the bus shows a result.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int RW    = CDB_ROB_ID_W;
    localparam int XW    = CDB_XLEN;
    localparam int REC_W = RW + 2 * XW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdy;
    logic          flush;
    logic [RW-1:0] rs_dest;
    logic [XW-1:0] rs_value;
    logic [XW-1:0] rs_next_pc;
    logic [RW-1:0] lsb_dest;
    logic [XW-1:0] lsb_value;
    logic          rs_almost_full;
    logic          lsb_almost_full;
    logic [RW-1:0] cdb_dest;
    logic [XW-1:0] cdb_value;
    logic [XW-1:0] cdb_next_pc;
    logic          cdb_from_lsb;

    logic [REC_W-1:0] exp_q [$];
    int tests = 0;
    int fails = 0;

    cdb_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .flush           (flush),
        .rs_dest         (rs_dest),
        .rs_value        (rs_value),
        .rs_next_pc      (rs_next_pc),
        .lsb_dest        (lsb_dest),
        .lsb_value       (lsb_value),
        .rs_almost_full  (rs_almost_full),
        .lsb_almost_full (lsb_almost_full),
        .cdb_dest        (cdb_dest),
        .cdb_value       (cdb_value),
        .cdb_next_pc     (cdb_next_pc),
        .cdb_from_lsb    (cdb_from_lsb)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [XW-1:0] rs_val(input logic [RW-1:0] t);
        return 32'h0000_0100 + XW'(t);
    endfunction
    function automatic logic [XW-1:0] rs_pc(input logic [RW-1:0] t);
        return 32'h0000_4000 + (XW'(t) << 2);
    endfunction
    function automatic logic [XW-1:0] lsb_val(input logic [RW-1:0] t);
        return 32'h0000_A000 + XW'(t);
    endfunction
    function automatic logic [REC_W-1:0] rs_rec(input logic [RW-1:0] t);
        return {t, rs_val(t), rs_pc(t), 1'b0};
    endfunction
    function automatic logic [REC_W-1:0] lsb_rec(input logic [RW-1:0] t);
        return {t, lsb_val(t), {XW{1'b0}}, 1'b1};
    endfunction
    function automatic logic [REC_W-1:0] cur_rec();
        return {cdb_dest, cdb_value, cdb_next_pc, cdb_from_lsb};
    endfunction

    task automatic chk(input string tag, input logic [REC_W-1:0] obs, input logic [REC_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_rs(input logic [RW-1:0] t);
        rs_dest = t; rs_value = rs_val(t); rs_next_pc = rs_pc(t);
    endtask
    task automatic drive_lsb(input logic [RW-1:0] t);
        lsb_dest = t; lsb_value = lsb_val(t);
    endtask
    task automatic clear_in();
        rs_dest = '0; rs_value = '0; rs_next_pc = '0;
        lsb_dest = '0; lsb_value = '0; flush = 1'b0;
    endtask

    // One clock edge; outputs are then either held (stall) or checked against the scoreboard.
    task automatic step();
        logic             rdy_edge;
        logic [REC_W-1:0] prev;
        logic [REC_W-1:0] exp;
        rdy_edge = rdy;
        prev     = cur_rec();
        @(posedge clk);
        #1;
        if (!rdy_edge) begin
            chk("stall_hold", cur_rec(), prev);
        end else if (cdb_dest != '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_bcast", cur_rec(), '0);
            end else begin
                exp = exp_q.pop_front();
                chk("cdb_bcast", cur_rec(), exp);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk("idle_dest", REC_W'(cdb_dest), '0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
        chk("drain_empty", REC_W'(exp_q.size()), '0);
    endtask

    logic [1:0] af_exp [9];

    initial begin
        rst = 1'b0; rdy = 1'b1;
        clear_in();
        #3;
        chk("reset_rec", cur_rec(), '0);
        chk("reset_af", REC_W'({rs_almost_full, lsb_almost_full}), '0);
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        chk("idle_af", REC_W'({rs_almost_full, lsb_almost_full}), '0);

        // Single RS result
        rs_dest = 5'd3; rs_value = 32'h11; rs_next_pc = 32'h104;
        exp_q.push_back({5'd3, 32'h11, 32'h104, 1'b0});
        step();
        clear_in();
        chk("no_bypass", REC_W'(cdb_dest), '0);
        step();
        chk("single_seen", REC_W'(exp_q.size()), '0);
        step();
        chk("single_pulse", REC_W'(cdb_dest), '0);

        // Flush puts last_grant back to LSB so RS wins the next tie
        flush = 1'b1;
        step();
        clear_in();
        idle(1);

        // Simultaneous pushes
        drive_rs(5'd2); drive_lsb(5'd5);
        exp_q.push_back(rs_rec(5'd2));
        exp_q.push_back(lsb_rec(5'd5));
        step();
        clear_in();
        step();
        chk("tie_rs_first", REC_W'(cdb_dest), REC_W'(5'd2));
        step();
        chk("tie_lsb_next", REC_W'({cdb_from_lsb, cdb_dest}), REC_W'({1'b1, 5'd5}));
        drain();
        idle(1);

        // Sustained contention, order 1,9,2,10,3,11,4,12
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(rs_rec(RW'(1 + i)));
            exp_q.push_back(lsb_rec(RW'(9 + i)));
        end
        for (int i = 0; i < 4; i++) begin
            drive_rs(RW'(1 + i)); drive_lsb(RW'(9 + i));
            step();
        end
        clear_in();
        drain();
        idle(1);

        // Deeper contention to exercise almost_full; {rs,lsb} after each edge
        af_exp = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b11, 2'b11, 2'b01, 2'b00};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(rs_rec(RW'(1 + i)));
            exp_q.push_back(lsb_rec(RW'(9 + i)));
        end
        for (int e = 0; e < 9; e++) begin
            if (e < 6) begin
                drive_rs(RW'(1 + e)); drive_lsb(RW'(9 + e));
            end else begin
                clear_in();
            end
            step();
            chk("almost_full", REC_W'({rs_almost_full, lsb_almost_full}), REC_W'(af_exp[e]));
        end
        clear_in();
        drain();
        idle(1);

        // Flush mid-stream with a same-cycle push of tag 7
        exp_q.push_back(rs_rec(5'd1));
        exp_q.push_back(lsb_rec(5'd17));
        exp_q.push_back(rs_rec(5'd2));
        exp_q.push_back(lsb_rec(5'd18));
        for (int i = 0; i < 5; i++) begin
            drive_rs(RW'(1 + i)); drive_lsb(RW'(17 + i));
            step();
        end
        chk("preflush_af", REC_W'({rs_almost_full, lsb_almost_full}), REC_W'(2'b11));
        clear_in();
        flush = 1'b1;
        drive_rs(5'd7);
        step();
        clear_in();
        chk("flush_cdb", cur_rec(), '0);
        chk("flush_af", REC_W'({rs_almost_full, lsb_almost_full}), '0);
        idle(6);
        chk("flush_scoreboard", REC_W'(exp_q.size()), '0);

        // rdy stall while tag 4 is on the bus
        exp_q.push_back(rs_rec(5'd4));
        exp_q.push_back(rs_rec(5'd6));
        drive_rs(5'd4);
        step();
        drive_rs(5'd6);
        step();
        chk("stall_pre", REC_W'(cdb_dest), REC_W'(5'd4));
        rdy = 1'b0;
        drive_rs(5'd9); drive_lsb(5'd10);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_dest", REC_W'(cdb_dest), REC_W'(5'd4));
        end
        rdy = 1'b1;
        clear_in();
        step();
        chk("resume_dest", REC_W'(cdb_dest), REC_W'(5'd6));
        idle(4);
        chk("final_scoreboard", REC_W'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
